// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and helpers for the multi-channel clock divider. Rev 1.0
`default_nettype none

package clkdiv_pkg;

  localparam int CLKDIV_DEFAULT_HALF = 4_999_999;
  localparam int CLKDIV_MAX_CH       = 16;

  // Width of a channel index; never narrower than one bit.
  function automatic int clkdiv_ch_w(input int n_ch);
    if (n_ch <= 2) return 1;
    return $clog2(n_ch);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_divider_channel.sv
// clock_divider_channel: one divided square output with boundary-aligned divisor reload.
// Optional o_tick-style rise strobe when CLKDIV_TICK_EN is defined. Rev 1.0
`default_nettype none

module clock_divider_channel import clkdiv_pkg::*; #(
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_pend,
  output logic             clk_out
`ifdef CLKDIV_TICK_EN
  ,
  output logic             tick
`endif
);

  localparam logic [CNT_W-1:0] RST_HALF = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] active;
  logic [CNT_W-1:0] shadow;
  logic             boundary;

  assign boundary = en && (count == active);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      active   <= RST_HALF;
      shadow   <= RST_HALF;
      cfg_pend <= 1'b0;
      clk_out  <= 1'b0;
`ifdef CLKDIV_TICK_EN
      tick     <= 1'b0;
`endif
    end else if (!en) begin
      count   <= '0;
      clk_out <= 1'b0;
`ifdef CLKDIV_TICK_EN
      tick    <= 1'b0;
`endif
      // Idle channel: a write lands directly and supersedes any stale shadow.
      if (cfg_we) begin
        active   <= cfg_div;
        cfg_pend <= 1'b0;
      end
    end else if (boundary) begin
      count   <= '0;
      clk_out <= ~clk_out;
`ifdef CLKDIV_TICK_EN
      tick    <= ~clk_out;
`endif
      // A write in the boundary cycle wins over the older shadowed value.
      if (cfg_we) begin
        active   <= cfg_div;
        cfg_pend <= 1'b0;
      end else if (cfg_pend) begin
        active   <= shadow;
        cfg_pend <= 1'b0;
      end
    end else begin
      count <= count + CNT_W'(1);
`ifdef CLKDIV_TICK_EN
      tick  <= 1'b0;
`endif
      if (cfg_we) begin
        shadow   <= cfg_div;
        cfg_pend <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: N_CH independent programmable clock dividers with a shared config port.
// Define CLKDIV_TICK_EN to add the per-channel o_tick rise strobe. Rev 1.0
`default_nettype none

module clock_divider_multi import clkdiv_pkg::*; #(
  parameter int N_CH         = 2,
  parameter int CNT_W        = 32,
  parameter int DEFAULT_HALF = CLKDIV_DEFAULT_HALF
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic [N_CH-1:0]               i_en,
  input  logic                          i_cfg_we,
  input  logic [clkdiv_ch_w(N_CH)-1:0]  i_cfg_ch,
  input  logic [CNT_W-1:0]              i_cfg_div,
  output logic [N_CH-1:0]               o_cfg_pend,
  output logic [N_CH-1:0]               o_clk
`ifdef CLKDIV_TICK_EN
  ,
  output logic [N_CH-1:0]               o_tick
`endif
);

  localparam int CH_W = clkdiv_ch_w(N_CH);

  logic [N_CH-1:0] ch_we;

  generate
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      // Out-of-range indices match no channel, so such writes fall away here.
      assign ch_we[c] = i_cfg_we && (i_cfg_ch == CH_W'(c));

      clock_divider_channel #(
        .CNT_W        (CNT_W),
        .DEFAULT_HALF (DEFAULT_HALF)
      ) u_channel (
        .clk      (i_clk),
        .rst      (i_reset),
        .en       (i_en[c]),
        .cfg_we   (ch_we[c]),
        .cfg_div  (i_cfg_div),
        .cfg_pend (o_cfg_pend[c]),
        .clk_out  (o_clk[c])
`ifdef CLKDIV_TICK_EN
        ,
        .tick     (o_tick[c])
`endif
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: vector table, corner sequences and random run against a time-based model.
`default_nettype none

module tb_clock_divider_multi;

  localparam int N_CH  = 3;
  localparam int CNT_W = 8;
  localparam int DHALF = 3;

  logic             clk;
  logic             rst;
  logic [N_CH-1:0]  en;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [N_CH-1:0]  cfg_pend;
  logic [N_CH-1:0]  dclk;
`ifdef CLKDIV_TICK_EN
  logic [N_CH-1:0]  tick;
`endif

  clock_divider_multi #(
    .N_CH         (N_CH),
    .CNT_W        (CNT_W),
    .DEFAULT_HALF (DHALF)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_en       (en),
    .i_cfg_we   (cfg_we),
    .i_cfg_ch   (cfg_ch),
    .i_cfg_div  (cfg_div),
    .o_cfg_pend (cfg_pend),
    .o_clk      (dclk)
`ifdef CLKDIV_TICK_EN
    ,
    .o_tick     (tick)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: each channel keeps the absolute cycle number of its next toggle.
  int t = 0;
  int m_deadline [N_CH];
  int m_div      [N_CH];
  int m_pdiv     [N_CH];
  bit m_run      [N_CH];
  bit m_pend     [N_CH];
  bit m_lvl      [N_CH];
  bit m_tick     [N_CH];

  function automatic void model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_deadline[c] = 0;
      m_div[c]      = DHALF;
      m_pdiv[c]     = DHALF;
      m_run[c]      = 1'b0;
      m_pend[c]     = 1'b0;
      m_lvl[c]      = 1'b0;
      m_tick[c]     = 1'b0;
    end
  endfunction

  function automatic void model_step();
    t++;
    for (int c = 0; c < N_CH; c++) begin
      bit wr;
      wr = cfg_we && (int'(cfg_ch) == c);
      if (!en[c]) begin
        m_run[c]  = 1'b0;
        m_lvl[c]  = 1'b0;
        m_tick[c] = 1'b0;
        if (wr) begin
          m_div[c]  = int'(cfg_div);
          m_pend[c] = 1'b0;
        end
      end else begin
        if (!m_run[c]) begin
          m_run[c]      = 1'b1;
          m_deadline[c] = t + m_div[c];
        end
        if (t == m_deadline[c]) begin
          m_lvl[c]  = ~m_lvl[c];
          m_tick[c] = m_lvl[c];
          if (wr) begin
            m_div[c]  = int'(cfg_div);
            m_pend[c] = 1'b0;
          end else if (m_pend[c]) begin
            m_div[c]  = m_pdiv[c];
            m_pend[c] = 1'b0;
          end
          m_deadline[c] = t + m_div[c] + 1;
        end else begin
          m_tick[c] = 1'b0;
          if (wr) begin
            m_pdiv[c] = int'(cfg_div);
            m_pend[c] = 1'b1;
          end
        end
      end
    end
  endfunction

  task automatic compare_model();
    logic [N_CH-1:0] e_clk, e_pend, e_tick;
    for (int c = 0; c < N_CH; c++) begin
      e_clk[c]  = m_lvl[c];
      e_pend[c] = m_pend[c];
      e_tick[c] = m_tick[c];
    end
    check("model_clk", 32'(dclk), 32'(e_clk));
    check("model_pend", 32'(cfg_pend), 32'(e_pend));
`ifdef CLKDIV_TICK_EN
    check("model_tick", 32'(tick), 32'(e_tick));
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_clk", 32'(dclk), 32'd0);
    check("reset_pend", 32'(cfg_pend), 32'd0);
  endtask

  task automatic wait_toggle(input int ch, output int n);
    logic prev;
    bit   seen;
    prev = dclk[ch];
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 64) begin
      cycle();
      n++;
      if (dclk[ch] !== prev) seen = 1'b1;
    end
    if (!seen) begin
      failed++;
      tests++;
      $display("FAIL toggle_timeout: channel %0d did not toggle within %0d cycles", ch, n);
    end
  endtask

  task automatic write_cfg(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = CNT_W'(div);
  endtask

  typedef struct {
    logic [N_CH-1:0]  en;
    logic             we;
    logic [1:0]       ch;
    logic [CNT_W-1:0] div;
    logic [N_CH-1:0]  exp_clk;
    logic [N_CH-1:0]  exp_pend;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int n;

    // Basic run from reset with D=3: rise after 4 enabled edges, toggle every 4.
    for (int i = 0; i < 12; i++) begin
      vecs[i].en       = 3'b011;
      vecs[i].we       = 1'b0;
      vecs[i].ch       = 2'd0;
      vecs[i].div      = '0;
      vecs[i].exp_clk  = ((i >= 3 && i <= 6) || i == 11) ? 3'b011 : 3'b000;
      vecs[i].exp_pend = 3'b000;
    end
    vecs[5].we  = 1'b1;  vecs[5].ch = 2'd3; vecs[5].div = 8'd0;
    vecs[8].we  = 1'b1;  vecs[8].ch = 2'd2; vecs[8].div = 8'd1;

    rst     = 1'b1;
    en      = '0;
    cfg_we  = 1'b0;
    cfg_ch  = '0;
    cfg_div = '0;
    @(negedge clk);
    apply_reset();

    for (int i = 0; i < 12; i++) begin
      en      = vecs[i].en;
      cfg_we  = vecs[i].we;
      cfg_ch  = vecs[i].ch;
      cfg_div = vecs[i].div;
      cycle();
      check("vec_clk", 32'(dclk), 32'(vecs[i].exp_clk));
      check("vec_pend", 32'(cfg_pend), 32'(vecs[i].exp_pend));
    end
    cfg_we = 1'b0;

    // Deferred update: write D=1 to ch0 while its counter is at 1.
    cycle();
    write_cfg(0, 1);
    cycle();
    cfg_we = 1'b0;
    check("defer_pend_set", 32'(cfg_pend[0]), 32'd1);
    wait_toggle(0, n);
    check("defer_first", 32'(n), 32'd2);
    check("defer_pend_clr", 32'(cfg_pend[0]), 32'd0);
    wait_toggle(0, n);
    check("defer_half", 32'(n), 32'd2);
    wait_toggle(1, n);
    wait_toggle(1, n);
    check("ch1_unaffected", 32'(n), 32'd4);

    // Write landing exactly on the boundary cycle.
    apply_reset();
    en = 3'b001;
    repeat (3) cycle();
    write_cfg(0, 5);
    cycle();
    cfg_we = 1'b0;
    check("bnd_clk", 32'(dclk[0]), 32'd1);
    check("bnd_pend", 32'(cfg_pend[0]), 32'd0);
    wait_toggle(0, n);
    check("bnd_half6", 32'(n), 32'd6);

    // Two writes before a boundary: the last one wins.
    cycle();
    write_cfg(0, 2);
    cycle();
    write_cfg(0, 0);
    cycle();
    cfg_we = 1'b0;
    check("ovr_pend", 32'(cfg_pend[0]), 32'd1);
    wait_toggle(0, n);
    wait_toggle(0, n);
    check("ovr_half_a", 32'(n), 32'd1);
    wait_toggle(0, n);
    check("ovr_half_b", 32'(n), 32'd1);

    // Disable mid-high, program D=0 while idle, then re-enable.
    apply_reset();
    en = 3'b011;
    wait_toggle(1, n);
    check("dis_first_rise", 32'(n), 32'd4);
    cycle();
    en = 3'b001;
    cycle();
    check("dis_low", 32'(dclk[1]), 32'd0);
    write_cfg(1, 0);
    cycle();
    cfg_we = 1'b0;
    check("dis_wr_pend", 32'(cfg_pend[1]), 32'd0);
    en = 3'b011;
    wait_toggle(1, n);
    check("d0_first", 32'(n), 32'd1);
    wait_toggle(1, n);
    check("d0_half", 32'(n), 32'd1);

    // Out-of-range channel index leaves everything untouched.
    write_cfg(3, 0);
    cycle();
    cfg_we = 1'b0;
    check("inv_pend", 32'(cfg_pend), 32'd0);
    wait_toggle(0, n);
    wait_toggle(0, n);
    check("inv_half", 32'(n), 32'd4);

    // Asynchronous reset between edges while a divisor is pending.
    apply_reset();
    en = 3'b001;
    repeat (4) cycle();
    check("ar_high", 32'(dclk[0]), 32'd1);
    cycle();
    write_cfg(0, 1);
    cycle();
    cfg_we = 1'b0;
    check("ar_pend_set", 32'(cfg_pend[0]), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_clk", 32'(dclk), 32'd0);
    check("ar_pend", 32'(cfg_pend), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    wait_toggle(0, n);
    check("ar_first", 32'(n), 32'd4);
    wait_toggle(0, n);
    check("ar_half", 32'(n), 32'd4);

    // Randomised traffic against the model.
    en = 3'b111;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) en[$urandom_range(0, N_CH - 1)] ^= 1'b1;
      cfg_we  = ($urandom_range(0, 5) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_div = CNT_W'($urandom_range(0, 5));
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("rand_ar_clk", 32'(dclk), 32'd0);
        #1 rst = 1'b0;
      end
      cycle();
    end
    cfg_we = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
